// File: rtl/cordic_sequencer.sv
// Control sequencer for an external iterative CORDIC rotation block.
// It range-reduces the request angle, seeds the block, and returns cos/sin/residual.
module cordic_sequencer #(
  parameter int unsigned        MAX_ITER      = 24,
  parameter logic signed [31:0] ANGLE_PI      = 32'sh3243F6A8,
  parameter logic signed [31:0] ANGLE_HALF_PI = 32'sh1921FB54,
  parameter logic signed [31:0] X_INIT        = 32'sh09B74EDA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_angle,
  input  logic        [31:0] iter_n,
  output logic               cb_valid,
  output logic signed [31:0] cb_x0,
  output logic signed [31:0] cb_y0,
  output logic signed [31:0] cb_z0,
  output logic        [31:0] cb_n,
  input  logic signed [31:0] cb_x,
  input  logic signed [31:0] cb_y,
  input  logic signed [31:0] cb_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_cos,
  output logic signed [31:0] out_sin,
  output logic signed [31:0] out_resid
);

  localparam logic [31:0] MAX_ITER_W = 32'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic        [31:0] cnt_q, cnt_d;
  logic signed [31:0] x0_q, y0_q, z0_q;
  logic        [31:0] n_q;
  logic               neg_q;
  logic signed [31:0] cos_q, sin_q, resid_q;

  logic signed [31:0] angle_sat;
  logic signed [31:0] z0_red;
  logic               neg_red;
  logic        [31:0] n_clamp;
  logic               load_seed;
  logic               capture;

  // Saturate to [-pi, pi], then fold into [-pi/2, pi/2]; the fold flips the
  // sign of cos and sin, which is restored at capture via neg_q.
  always_comb begin
    angle_sat = in_angle;
    if (in_angle > ANGLE_PI) begin
      angle_sat = ANGLE_PI;
    end else if (in_angle < -ANGLE_PI) begin
      angle_sat = -ANGLE_PI;
    end

    z0_red  = angle_sat;
    neg_red = 1'b0;
    if (angle_sat > ANGLE_HALF_PI) begin
      z0_red  = angle_sat - ANGLE_PI;
      neg_red = 1'b1;
    end else if (angle_sat < -ANGLE_HALF_PI) begin
      z0_red  = angle_sat + ANGLE_PI;
      neg_red = 1'b1;
    end

    n_clamp = iter_n;
    if (iter_n == 32'd0) begin
      n_clamp = 32'd1;
    end else if (iter_n > MAX_ITER_W) begin
      n_clamp = MAX_ITER_W;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_seed = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_seed = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 32'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == n_q - 32'd1) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CAPT: begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values; the async reset clears all of it, aborting any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      z0_q    <= '0;
      n_q     <= '0;
      neg_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      resid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_seed) begin
        x0_q  <= X_INIT;
        y0_q  <= '0;
        z0_q  <= z0_red;
        n_q   <= n_clamp;
        neg_q <= neg_red;
      end
      if (capture) begin
        cos_q   <= neg_q ? -cb_x : cb_x;
        sin_q   <= neg_q ? -cb_y : cb_y;
        resid_q <= cb_z;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign cb_valid  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);
  assign cb_x0     = x0_q;
  assign cb_y0     = y0_q;
  assign cb_z0     = z0_q;
  assign cb_n      = n_q;
  assign out_cos   = cos_q;
  assign out_sin   = sin_q;
  assign out_resid = resid_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer with a behavioural model of the
// downstream CORDIC rotation block attached to the cb_* ports.
module tb_cordic_sequencer;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_angle;
  logic        [31:0] iter_n;
  logic               cb_valid;
  logic signed [31:0] cb_x0, cb_y0, cb_z0;
  logic        [31:0] cb_n;
  logic signed [31:0] cb_x, cb_y, cb_z;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_cos, out_sin, out_resid;

  int n_vec  = 0;
  int n_fail = 0;

  cordic_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .iter_n    (iter_n),
    .cb_valid  (cb_valid),
    .cb_x0     (cb_x0),
    .cb_y0     (cb_y0),
    .cb_z0     (cb_z0),
    .cb_n      (cb_n),
    .cb_x      (cb_x),
    .cb_y      (cb_y),
    .cb_z      (cb_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_resid (out_resid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream CORDIC block: loads on cb_valid, then one rotation per edge.
  int                 atan_tab [0:31];
  logic signed [31:0] m_x, m_y, m_z;
  int                 m_n, m_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x <= '0; m_y <= '0; m_z <= '0; m_n <= 0; m_i <= 0;
    end else if (cb_valid) begin
      m_x <= cb_x0; m_y <= cb_y0; m_z <= cb_z0; m_n <= int'(cb_n); m_i <= 0;
    end else if (m_i < m_n && m_i < 32) begin
      if (m_z >= 0) begin
        m_x <= m_x - (m_y >>> m_i);
        m_y <= m_y + (m_x >>> m_i);
        m_z <= m_z - atan_tab[m_i];
      end else begin
        m_x <= m_x + (m_y >>> m_i);
        m_y <= m_y - (m_x >>> m_i);
        m_z <= m_z + atan_tab[m_i];
      end
      m_i <= m_i + 1;
    end
  end

  assign cb_x = m_x;
  assign cb_y = m_y;
  assign cb_z = m_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act,
                           input logic [31:0] exp, input int tol);
    longint diff;
    diff = longint'($signed(act)) - longint'($signed(exp));
    if (diff < 0) diff = -diff;
    n_vec++;
    if (diff > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h +/- %0d", name, act, exp, tol);
    end
  endtask

  // Present a request and take the accept edge; returns with time #1 past it.
  task automatic do_accept(input logic [31:0] angle, input logic [31:0] iters,
                           input bit keep_valid);
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = angle;
    iter_n   = iters;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    check("cb_valid_load", 32'(cb_valid), 32'd1);
    check("cb_x0_seed", cb_x0, 32'h09B74EDA);
    check("cb_y0_seed", cb_y0, 32'h0);
  endtask

  // Edges counted inclusively: the accept edge is 1, the out_valid edge is last.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_done();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("released_valid", 32'(out_valid), 32'd0);
    check("released_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] angle;
    logic [31:0] iters;
    logic [31:0] exp_n;
    logic [31:0] exp_z0;
    logic [31:0] exp_cos;
    logic [31:0] exp_sin;
    int          tol;
  } vec_t;

  localparam real SCALE = 268435456.0;

  vec_t vecs [0:8];

  task automatic run_vec(input vec_t v);
    int edges;
    do_accept(v.angle, v.iters, 1'b0);
    check("cb_z0", cb_z0, v.exp_z0);
    check("cb_n", cb_n, v.exp_n);
    wait_done(edges);
    check("latency", 32'(edges), v.exp_n + 32'd3);
    check_tol("out_cos", out_cos, v.exp_cos, v.tol);
    check_tol("out_sin", out_sin, v.exp_sin, v.tol);
    if (v.tol > 0) check_tol("out_resid", out_resid, 32'h0, 256);
    release_done();
  endtask

  initial begin
    int                 edges;
    logic signed [31:0] exp_c, exp_s;

    for (int i = 0; i < 32; i++)
      atan_tab[i] = int'($atan(2.0 ** (-i)) * SCALE);

    vecs[0] = '{32'h00000000, 32'd24,  32'd24, 32'h00000000, 32'h10000000, 32'h00000000, 256};
    vecs[1] = '{32'h1921FB54, 32'd24,  32'd24, 32'h1921FB54, 32'h00000000, 32'h10000000, 256};
    vecs[2] = '{32'h3243F6A8, 32'd24,  32'd24, 32'h00000000, 32'hF0000000, 32'h00000000, 256};
    vecs[3] = '{32'h40000000, 32'd24,  32'd24, 32'h00000000, 32'hF0000000, 32'h00000000, 256};
    vecs[4] = '{32'hCDBC0958, 32'd24,  32'd24, 32'h00000000, 32'hF0000000, 32'h00000000, 256};
    vecs[5] = '{32'hE6DE04AC, 32'd24,  32'd24, 32'hE6DE04AC, 32'h00000000, 32'hF0000000, 256};
    vecs[6] = '{32'h30000000, 32'd24,  32'd24, 32'hFDBC0958,
                32'(int'($cos(3.0) * SCALE)), 32'(int'($sin(3.0) * SCALE)), 256};
    vecs[7] = '{32'hE0000000, 32'd100, 32'd24, 32'h1243F6A8,
                32'(int'($cos(-2.0) * SCALE)), 32'(int'($sin(-2.0) * SCALE)), 256};
    // One iteration from angle 0: x = K, y = K exactly.
    vecs[8] = '{32'h00000000, 32'd0,   32'd1,  32'h00000000, 32'h09B74EDA, 32'h09B74EDA, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_angle  = '0;
    iter_n    = '0;
    out_ready = 1'b0;
    #12;
    check("rst_cb_valid", 32'(cb_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_cos", out_cos, 32'h0);
    check("rst_cb_n", cb_n, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Hold DONE with a pending request that must be ignored and not queued.
    do_accept(32'h00000000, 32'd4, 1'b1);
    in_angle = 32'h10000000;
    wait_done(edges);
    exp_c = m_x;
    exp_s = m_y;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_cos", out_cos, exp_c);
      check("hold_sin", out_sin, exp_s);
    end
    release_done();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("dropped_req_ready", 32'(in_ready), 32'd1);
    check("dropped_req_load", 32'(cb_valid), 32'd0);

    // Back-to-back: accept on the edge right after DONE -> IDLE.
    do_accept(32'h00000000, 32'd2, 1'b0);
    wait_done(edges);
    check("b2b_latency", 32'(edges), 32'd5);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_angle  = 32'h08000000;
    iter_n    = 32'd24;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_idle", 32'(in_ready), 32'd1);
    check("b2b_no_bypass", 32'(cb_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accept", 32'(cb_valid), 32'd1);
    check("b2b_z0", cb_z0, 32'h08000000);
    wait_done(edges);
    check_tol("b2b_cos", out_cos, 32'(int'($cos(0.5) * SCALE)), 256);
    check_tol("b2b_sin", out_sin, 32'(int'($sin(0.5) * SCALE)), 256);
    release_done();

    // Reset mid-RUN aborts the run and clears every output immediately.
    do_accept(32'h1921FB54, 32'd24, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_cb_valid", 32'(cb_valid), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_cb_x0", cb_x0, 32'h0);
    check("abort_cb_z0", cb_z0, 32'h0);
    check("abort_cb_n", cb_n, 32'h0);
    check("abort_out_cos", out_cos, 32'h0);
    check("abort_out_sin", out_sin, 32'h0);
    check("abort_out_resid", out_resid, 32'h0);
    repeat (30) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 Parameters SHALL be as follows; all angles are signed radians scaled by 2^28:
  - MAX_ITER, 24, upper clamp for iteration count.
  - ANGLE_PI, 32'h3243F6A8, pi.
  - ANGLE_HALF_PI, 32'h1921FB54, pi/2.
  - X_INIT, 32'h09B74EDA, CORDIC gain K as seed x.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, single clock; all state changes on its rising edge.
  - rst_n, in, 1, asynchronous, active-low reset.
  - in_valid, in, 1, request strobe.
  - in_ready, out, 1, sequencer can accept.
  - in_angle, in, 32 signed, target angle.
  - iter_n, in, 32, requested iteration count.
  - cb_valid, out, 1, load strobe to the CORDIC iteration block.
  - cb_x0, cb_y0, cb_z0, out, 32 signed each, seed values.
  - cb_n, out, 32, iteration count to the block.
  - cb_x, cb_y, cb_z, in, 32 signed each, block results.
  - out_valid, out, 1, result available.
  - out_ready, in, 1, consumer accepts.
  - out_cos, out_sin, out_resid, out, 32 signed each, results.

Function
REQ-003 States SHALL be IDLE, LOAD, RUN, CAPT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-004 Accept: on the first edge in IDLE with in_valid=1, the block SHALL:
  - latch in_angle and iter_n;
  - clamp the latched count to the range 1..MAX_ITER (0 becomes 1; values above MAX_ITER become MAX_ITER);
  - move to LOAD.
REQ-005 A latched angle above ANGLE_PI SHALL saturate to ANGLE_PI; one below -ANGLE_PI SHALL saturate to -ANGLE_PI.
REQ-006 Range reduction SHALL be:
  - angle > ANGLE_HALF_PI: z0 = angle - ANGLE_PI, neg flag = 1;
  - angle < -ANGLE_HALF_PI: z0 = angle + ANGLE_PI, neg flag = 1;
  - otherwise: z0 = angle, neg flag = 0.
  Exactly ±ANGLE_HALF_PI is not reduced.
REQ-007 Seeds SHALL be cb_x0 = X_INIT, cb_y0 = 0, cb_z0 = reduced angle and cb_n = clamped count; all are registered and held stable from LOAD through CAPT.
REQ-008 LOAD SHALL last exactly one cycle with cb_valid = 1; cb_valid SHALL be 0 in every other state.
REQ-009 RUN SHALL last exactly cb_n cycles, counted by an internal counter cleared on entry, then move to CAPT.
REQ-010 CAPT SHALL last one cycle; on its closing edge the block SHALL register the results and enter DONE with out_valid = 1:
  - out_cos = neg ? -cb_x : cb_x;
  - out_sin = neg ? -cb_y : cb_y;
  - out_resid = cb_z.
  Negation is 32-bit two's complement.
REQ-011 Latency SHALL be cb_n + 3 rising edges from the accept edge to the edge that raises out_valid.
REQ-012 In DONE, out_valid and all out_* values SHALL hold until an edge with out_ready = 1; that edge SHALL return the block to IDLE and clear out_valid.
REQ-013 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-014 A new accept SHALL be possible on the edge immediately after the DONE-to-IDLE transition; there is no bypass of IDLE.
REQ-015 Each run SHALL reload the downstream block through cb_valid, so no stale block state affects results.

Reset
REQ-016 While rst_n = 0, asynchronously:
  - state = IDLE;
  - cb_valid, out_valid = 0;
  - in_ready = 1 once rst_n = 1;
  - cb_x0, cb_y0, cb_z0, cb_n, out_cos, out_sin, out_resid, the counter and the neg flag = 0.
REQ-017 Reset asserted in any state SHALL abort the run with no out_valid pulse; the first accept after release SHALL behave as after power-up.

Verification
REQ-018 The bench SHALL cover the following scenarios; numeric tolerance is ±256 LSB against 2^28 = 1.0:
  - in_angle = 0, iter_n = 24 -> out_cos ≈ 32'h10000000, out_sin ≈ 0; out_valid rises 27 edges after accept.
  - in_angle = 32'h1921FB54, iter_n = 24 -> not reduced; out_cos ≈ 0, out_sin ≈ 32'h10000000.
  - in_angle = 32'h3243F6A8 -> cb_z0 = 0, neg = 1; out_cos ≈ 32'hF0000000, out_sin ≈ 0. in_angle = 32'h40000000 -> same result via saturation.
  - iter_n = 0 -> cb_n = 1, out_valid 4 edges after accept. iter_n = 100 -> cb_n = 24.
  - out_ready held 0 for 5 cycles in DONE with in_valid = 1 -> out_* stable, in_ready = 0, the request is dropped; out_ready = 1 -> IDLE next edge.
  - rst_n pulsed low mid-RUN -> all outputs 0 immediately, no out_valid; a following request with in_angle = 0 completes correctly.
